// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-port round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 2;
  localparam int unsigned DEFAULT_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT1 = 2'b01,
    GRANT2 = 2'b10
  } state_e;

  // Port ids double as the mux select value for that port
  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;

endpackage

// File: rtl/mux2_out_stage.sv
// WIDTH-bit 2:1 data select feeding a one-entry valid/ready output register.
module mux2_out_stage
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic             load,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] mux_c;

  assign mux_c = sel ? data_2 : data_1;

  // A load wins over a consume so back-to-back words keep Out_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= mux_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two requesters, with a
// burst limit so a busy port cannot starve the other.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req_1,
  input  logic [WIDTH-1:0] Data_1,
  output logic             Ack_1,
  input  logic             Req_2,
  input  logic [WIDTH-1:0] Data_2,
  output logic             Ack_2,
  output logic             S,
  output logic [WIDTH-1:0] Out,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_e           state_q, state_d;
  logic             s_q, s_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;

  logic             can_load_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             burst_done_c;

  assign can_load_c   = !Out_valid || Out_ready;
  assign Ack_1        = (state_q == GRANT1) && Req_1 && can_load_c;
  assign Ack_2        = (state_q == GRANT2) && Req_2 && can_load_c;
  assign cnt_inc_c    = burst_q + CNT_W'(1);
  assign burst_done_c = (cnt_inc_c == CNT_W'(MAX_BURST));
  assign S            = s_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      s_q     <= PORT1;
      last_q  <= PORT2;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Next state; every grant entry reloads select, last and the burst count
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (Req_1 && (!Req_2 || (last_q == PORT2))) begin
          state_d = GRANT1;
          s_d     = PORT1;
          last_d  = PORT1;
          burst_d = '0;
        end else if (Req_2) begin
          state_d = GRANT2;
          s_d     = PORT2;
          last_d  = PORT2;
          burst_d = '0;
        end
      end
      GRANT1: begin
        if (!Req_1) begin
          if (Req_2) begin
            state_d = GRANT2;
            s_d     = PORT2;
            last_d  = PORT2;
            burst_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (Ack_1) begin
          if (!burst_done_c) begin
            burst_d = cnt_inc_c;
          end else if (Req_2) begin
            state_d = GRANT2;
            s_d     = PORT2;
            last_d  = PORT2;
            burst_d = '0;
          end else begin
            burst_d = '0;
          end
        end
      end
      GRANT2: begin
        if (!Req_2) begin
          if (Req_1) begin
            state_d = GRANT1;
            s_d     = PORT1;
            last_d  = PORT1;
            burst_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (Ack_2) begin
          if (!burst_done_c) begin
            burst_d = cnt_inc_c;
          end else if (Req_1) begin
            state_d = GRANT1;
            s_d     = PORT1;
            last_d  = PORT1;
            burst_d = '0;
          end else begin
            burst_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mux2_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .sel       (s_q),
    .data_1    (Data_1),
    .data_2    (Data_2),
    .load      (Ack_1 || Ack_2),
    .out_ready (Out_ready),
    .out       (Out),
    .out_valid (Out_valid)
  );

endmodule
